// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg : shared VGA geometry defaults and motion FSM encoding.  Rev 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam int VGA_SCREEN_W = 640;
  localparam int VGA_SCREEN_H = 480;
  localparam int VGA_BOX_SIZE = 200;
  localparam int VGA_POS_W    = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_CALC_X = 3'd2,
    ST_CALC_Y = 3'd3,
    ST_COMMIT = 3'd4
  } motion_state_e;

  function automatic logic is_busy(input motion_state_e s);
    return (s == ST_CALC_X) || (s == ST_CALC_Y) || (s == ST_COMMIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/box_motion_ctrl_axis_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_step : combinational bounce/clamp step for one axis.  Rev 1.0
// ----------------------------------------------------------------------------
module axis_step
  import vga_pkg::*;
#(
  parameter int POS_W    = VGA_POS_W,
  parameter int BOX_SIZE = VGA_BOX_SIZE
) (
  input  logic [POS_W-1:0] pos_i,
  input  logic             dir_i,
  input  logic [2:0]       speed_i,
  input  logic [POS_W:0]   limit_i,    // screen dimension minus one
  input  logic [POS_W-1:0] max_pos_i,  // limit_i minus BOX_SIZE
  output logic [POS_W-1:0] pos_o,
  output logic             dir_o,
  output logic             flip_o
);

  localparam int XW = POS_W + 1;

  logic [XW-1:0] w_pos_ext;
  logic [XW-1:0] w_speed_ext;
  logic [XW-1:0] w_far_edge;

  always_comb begin
    w_pos_ext   = {1'b0, pos_i};
    w_speed_ext = XW'(speed_i);
    w_far_edge  = w_pos_ext + XW'(BOX_SIZE) + w_speed_ext;
    pos_o       = pos_i;
    flip_o      = 1'b0;
    if (!dir_i) begin
      if (w_far_edge >= limit_i) begin
        pos_o  = max_pos_i;
        flip_o = 1'b1;
      end else begin
        pos_o  = pos_i + POS_W'(speed_i);
      end
    end else begin
      if (w_pos_ext < w_speed_ext) begin
        pos_o  = '0;
        flip_o = 1'b1;
      end else begin
        pos_o  = pos_i - POS_W'(speed_i);
      end
    end
    dir_o = dir_i ^ flip_o;
  end

endmodule
`default_nettype wire

// File: rtl/box_motion_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// box_motion_ctrl : frame-synchronous bouncing-box position sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
module box_motion_ctrl
  import vga_pkg::*;
#(
  parameter int SCREEN_W = VGA_SCREEN_W,
  parameter int SCREEN_H = VGA_SCREEN_H,
  parameter int BOX_SIZE = VGA_BOX_SIZE,
  parameter int POS_W    = VGA_POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pause,
  input  logic             frame_start,
  input  logic [2:0]       speed,
  input  logic [1:0]       frame_div,
  input  logic             load,
  input  logic [POS_W-1:0] load_x,
  input  logic [POS_W-1:0] load_y,
  output logic [POS_W-1:0] box_x,
  output logic [POS_W-1:0] box_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic             bounce_x,
  output logic             bounce_y,
  output logic             corner,
  output logic             busy,
  output logic             overrun
);

  localparam logic [POS_W:0]   C_X_LIM = (POS_W+1)'(SCREEN_W - 1);
  localparam logic [POS_W:0]   C_Y_LIM = (POS_W+1)'(SCREEN_H - 1);
  localparam logic [POS_W-1:0] C_X_MAX = POS_W'(SCREEN_W - 1 - BOX_SIZE);
  localparam logic [POS_W-1:0] C_Y_MAX = POS_W'(SCREEN_H - 1 - BOX_SIZE);

  motion_state_e    state_q, state_d;
  logic [POS_W-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [POS_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic             sh_dir_x_q, sh_dir_x_d, sh_dir_y_q, sh_dir_y_d;
  logic             sh_flip_x_q, sh_flip_x_d, sh_flip_y_q, sh_flip_y_d;
  logic [2:0]       speed_q, speed_d;
  logic [1:0]       div_cnt_q, div_cnt_d;
  logic             bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
  logic             corner_q, corner_d;
  logic             overrun_q, overrun_d;

  logic [POS_W-1:0] w_step_pos, w_step_max, w_step_pos_o;
  logic [POS_W:0]   w_step_lim;
  logic             w_step_dir, w_step_dir_o, w_step_flip;
  logic             w_busy;

  assign w_busy = is_busy(state_q);

  // One stepper shared between the two axes; CALC_Y selects the y operands.
  always_comb begin
    w_step_pos = box_x_q;
    w_step_dir = dir_x_q;
    w_step_lim = C_X_LIM;
    w_step_max = C_X_MAX;
    if (state_q == ST_CALC_Y) begin
      w_step_pos = box_y_q;
      w_step_dir = dir_y_q;
      w_step_lim = C_Y_LIM;
      w_step_max = C_Y_MAX;
    end
  end

  axis_step #(
    .POS_W    (POS_W),
    .BOX_SIZE (BOX_SIZE)
  ) u_axis_step (
    .pos_i     (w_step_pos),
    .dir_i     (w_step_dir),
    .speed_i   (speed_q),
    .limit_i   (w_step_lim),
    .max_pos_i (w_step_max),
    .pos_o     (w_step_pos_o),
    .dir_o     (w_step_dir_o),
    .flip_o    (w_step_flip)
  );

  always_comb begin
    state_d     = state_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    sh_x_d      = sh_x_q;
    sh_y_d      = sh_y_q;
    sh_dir_x_d  = sh_dir_x_q;
    sh_dir_y_d  = sh_dir_y_q;
    sh_flip_x_d = sh_flip_x_q;
    sh_flip_y_d = sh_flip_y_q;
    speed_d     = speed_q;
    div_cnt_d   = div_cnt_q;
    bounce_x_d  = 1'b0;
    bounce_y_d  = 1'b0;
    corner_d    = 1'b0;
    overrun_d   = overrun_q;

    // A strobe during an in-flight update is dropped but remembered.
    if (frame_start && w_busy) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          box_x_d   = (load_x > C_X_MAX) ? C_X_MAX : load_x;
          box_y_d   = (load_y > C_Y_MAX) ? C_Y_MAX : load_y;
          dir_x_d   = 1'b0;
          dir_y_d   = 1'b0;
          overrun_d = 1'b0;
        end
        if (enable) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (frame_start && !pause) begin
          if (div_cnt_q == frame_div) begin
            div_cnt_d = '0;
            speed_d   = speed;
            state_d   = ST_CALC_X;
          end else begin
            div_cnt_d = div_cnt_q + 2'd1;
          end
        end
      end
      ST_CALC_X: begin
        sh_x_d      = w_step_pos_o;
        sh_dir_x_d  = w_step_dir_o;
        sh_flip_x_d = w_step_flip;
        state_d     = ST_CALC_Y;
      end
      ST_CALC_Y: begin
        sh_y_d      = w_step_pos_o;
        sh_dir_y_d  = w_step_dir_o;
        sh_flip_y_d = w_step_flip;
        state_d     = ST_COMMIT;
      end
      ST_COMMIT: begin
        box_x_d    = sh_x_q;
        box_y_d    = sh_y_q;
        dir_x_d    = sh_dir_x_q;
        dir_y_d    = sh_dir_y_q;
        bounce_x_d = sh_flip_x_q;
        bounce_y_d = sh_flip_y_q;
        corner_d   = sh_flip_x_q & sh_flip_y_q;
        state_d    = ST_WAIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      box_x_q     <= '0;
      box_y_q     <= '0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      sh_x_q      <= '0;
      sh_y_q      <= '0;
      sh_dir_x_q  <= 1'b0;
      sh_dir_y_q  <= 1'b0;
      sh_flip_x_q <= 1'b0;
      sh_flip_y_q <= 1'b0;
      speed_q     <= '0;
      div_cnt_q   <= '0;
      bounce_x_q  <= 1'b0;
      bounce_y_q  <= 1'b0;
      corner_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      sh_dir_x_q  <= sh_dir_x_d;
      sh_dir_y_q  <= sh_dir_y_d;
      sh_flip_x_q <= sh_flip_x_d;
      sh_flip_y_q <= sh_flip_y_d;
      speed_q     <= speed_d;
      div_cnt_q   <= div_cnt_d;
      bounce_x_q  <= bounce_x_d;
      bounce_y_q  <= bounce_y_d;
      corner_q    <= corner_d;
      overrun_q   <= overrun_d;
    end
  end

  assign box_x    = box_x_q;
  assign box_y    = box_y_q;
  assign dir_x    = dir_x_q;
  assign dir_y    = dir_y_q;
  assign bounce_x = bounce_x_q;
  assign bounce_y = bounce_y_q;
  assign corner   = corner_q;
  assign busy     = w_busy;
  assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_box_motion_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_box_motion_ctrl : directed + randomized bench with a behavioural model.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_box_motion_ctrl;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int B  = 200;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          pause = 1'b0;
  logic          frame_start = 1'b0;
  logic [2:0]    speed = 3'd0;
  logic [1:0]    frame_div = 2'd0;
  logic          load = 1'b0;
  logic [PW-1:0] load_x = '0;
  logic [PW-1:0] load_y = '0;
  logic [PW-1:0] box_x, box_y;
  logic          dir_x, dir_y, bounce_x, bounce_y, corner, busy, overrun;

  box_motion_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pause       (pause),
    .frame_start (frame_start),
    .speed       (speed),
    .frame_div   (frame_div),
    .load        (load),
    .load_x      (load_x),
    .load_y      (load_y),
    .box_x       (box_x),
    .box_y       (box_y),
    .dir_x       (dir_x),
    .dir_y       (dir_y),
    .bounce_x    (bounce_x),
    .bounce_y    (bounce_y),
    .corner      (corner),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int commits = 0;
  logic mon_en = 1'b0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an update is resolved when triggered and lands 3 edges later.
  int m_run = 0, m_left = 0, m_cnt = 0;
  int m_x = 0, m_y = 0, m_dx = 0, m_dy = 0, m_bx = 0, m_by = 0, m_cn = 0, m_ovr = 0;
  int p_x = 0, p_y = 0, p_dx = 0, p_dy = 0, p_fx = 0, p_fy = 0;

  function automatic void axis(input int pos, input int dir, input int spd, input int lim,
                               output int np, output int nd, output int fl);
    fl = 0;
    if (dir == 0) begin
      if (pos + B + spd >= lim - 1) begin np = lim - 1 - B; fl = 1; end
      else np = pos + spd;
    end else begin
      if (pos < spd) begin np = 0; fl = 1; end
      else np = pos - spd;
    end
    nd = fl ? 1 - dir : dir;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_run = 0; m_left = 0; m_cnt = 0; m_x = 0; m_y = 0; m_dx = 0; m_dy = 0;
        m_bx = 0; m_by = 0; m_cn = 0; m_ovr = 0;
      end else begin
        m_bx = 0; m_by = 0; m_cn = 0;
        if (m_left > 0) begin
          if (frame_start) m_ovr = 1;
          m_left--;
          if (m_left == 0) begin
            m_x = p_x; m_y = p_y; m_dx = p_dx; m_dy = p_dy;
            m_bx = p_fx; m_by = p_fy; m_cn = p_fx & p_fy;
          end
        end else if (m_run == 0) begin
          if (load) begin
            m_x = (int'(load_x) > W - 1 - B) ? W - 1 - B : int'(load_x);
            m_y = (int'(load_y) > H - 1 - B) ? H - 1 - B : int'(load_y);
            m_dx = 0; m_dy = 0; m_ovr = 0;
          end
          if (enable) m_run = 1;
        end else if (!enable) begin
          m_run = 0;
        end else if (frame_start && !pause) begin
          if (m_cnt == int'(frame_div)) begin
            m_cnt = 0;
            axis(m_x, m_dx, int'(speed), W, p_x, p_dx, p_fx);
            axis(m_y, m_dy, int'(speed), H, p_y, p_dy, p_fy);
            m_left = 3;
          end else begin
            m_cnt = (m_cnt + 1) % 4;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("box_x", box_x, m_x);
        chk("box_y", box_y, m_y);
        chk("dir_x", dir_x, m_dx);
        chk("dir_y", dir_y, m_dy);
        chk("bounce_x", bounce_x, m_bx);
        chk("bounce_y", bounce_y, m_by);
        chk("corner", corner, m_cn);
        chk("busy", busy, (m_left > 0) ? 1 : 0);
        chk("overrun", overrun, m_ovr);
      end
      if (prev_busy && busy === 1'b0) commits++;
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic idle_load(input int x, input int y);
    enable = 1'b0;
    tick();
    load = 1'b1; load_x = PW'(x); load_y = PW'(y); enable = 1'b1;
    tick();
    load = 1'b0;
  endtask

  int c0;

  initial begin
    tick(); tick();
    chk("reset_box_x", box_x, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Basic +5 step, latency and busy window
    speed = 3'd5; frame_div = 2'd0;
    load = 1'b1; load_x = '0; load_y = '0; enable = 1'b1;
    tick();
    load = 1'b0;
    strobe();
    chk("busy_c1", busy, 1); tick();
    chk("busy_c2", busy, 1); tick();
    chk("busy_c3", busy, 1);
    chk("no_tear_x", box_x, 0); tick();
    chk("busy_done", busy, 0);
    chk("step_x", box_x, 5);
    chk("step_y", box_y, 5);
    chk("step_nopulse", bounce_x | bounce_y, 0);

    // Far-edge clamp on both axes -> corner
    idle_load(435, 275);
    strobe(); tick(); tick(); tick();
    chk("clamp_x", box_x, 439);
    chk("clamp_y", box_y, 279);
    chk("clamp_dir_x", dir_x, 1);
    chk("clamp_corner", corner, 1);
    tick();
    chk("corner_one_cycle", corner, 0);

    // Walk left to x=4, then one more frame hits the left wall
    for (int i = 0; i < 87; i++) begin
      strobe(); tick(); tick(); tick(); tick();
    end
    chk("walk_x", box_x, 4);
    strobe(); tick(); tick(); tick();
    chk("left_x", box_x, 0);
    chk("left_dir", dir_x, 0);
    chk("left_bounce", bounce_x, 1);
    chk("left_y", box_y, 160);

    // Frame divider and pause
    frame_div = 2'd2;
    c0 = commits;
    for (int i = 0; i < 6; i++) begin
      strobe(); tick(); tick(); tick(); tick();
    end
    chk("div_commits", commits - c0, 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe(); tick(); tick(); tick(); tick();
    end
    pause = 1'b0;
    chk("pause_commits", commits - c0, 2);
    for (int i = 0; i < 2; i++) begin
      strobe(); tick(); tick(); tick(); tick();
    end
    chk("held_count", commits - c0, 2);
    strobe(); tick(); tick(); tick(); tick();
    chk("third_strobe", commits - c0, 3);

    // Overrun: second strobe lands while busy
    frame_div = 2'd0;
    idle_load(100, 100);
    c0 = commits;
    strobe(); tick(); strobe();
    tick(); tick(); tick(); tick(); tick();
    chk("ovr_x", box_x, 105);
    chk("ovr_y", box_y, 105);
    chk("ovr_flag", overrun, 1);
    chk("ovr_commits", commits - c0, 1);
    enable = 1'b0;
    tick();
    load = 1'b1; load_x = PW'(1000); load_y = PW'(600);
    tick();
    load = 1'b0;
    chk("ovr_cleared", overrun, 0);
    chk("load_clamp_x", box_x, 439);
    chk("load_clamp_y", box_y, 279);

    // Asynchronous reset during CALC_Y
    enable = 1'b1;
    tick();
    strobe(); tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_box_x", box_x, 0);
    chk("arst_box_y", box_y, 0);
    tick();
    reset = 1'b0;
    tick(); tick(); tick(); tick();
    chk("arst_nopulse", bounce_x | bounce_y | corner, 0);

    // Randomized phase
    for (int i = 0; i < 2500; i++) begin
      tick();
      reset       = ($urandom_range(0, 299) == 0);
      enable      = ($urandom_range(0, 7) != 0);
      pause       = ($urandom_range(0, 9) == 0);
      frame_start = ($urandom_range(0, 3) == 0);
      speed       = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) frame_div = 2'($urandom_range(0, 3));
      load   = ($urandom_range(0, 4) == 0);
      load_x = PW'($urandom_range(0, 1023));
      load_y = PW'($urandom_range(0, 1023));
    end
    reset = 1'b0; frame_start = 1'b0; load = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/box_motion_ctrl.md
Name: box_motion_ctrl

Overview:
Frame-synchronous motion controller for the VGA bouncing-box renderer. It sequences one position update per selected frame. Updates run during vertical blanking through a small FSM, and the visible coordinates are committed atomically. The renderer's pixel compare logic consumes box_x/box_y. Runs entirely in the pixel clock domain; the pixel-rate vsync clock is replaced by a one-cycle frame_start strobe from the sync generator.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
BOX_SIZE, 200, box edge length in pixels
POS_W, 10, coordinate width

Ports:
clk  in  1  pixel clock
reset  in  1  reset, asynchronous, active-high
enable  in  1  1 = run FSM; 0 = park in IDLE
pause  in  1  1 = ignore frame_start (motion frozen)
frame_start  in  1  one-clk strobe at start of vertical blanking
speed  in  3  pixels moved per update, 0..7
frame_div  in  2  update every frame_div+1 frames
load  in  1  load start position (honoured in IDLE only)
load_x  in  POS_W  start x
load_y  in  POS_W  start y
box_x  out  POS_W  committed left edge
box_y  out  POS_W  committed top edge
dir_x  out  1  0 = right, 1 = left
dir_y  out  1  0 = down, 1 = up
bounce_x  out  1  one-clk pulse, x direction flipped this commit
bounce_y  out  1  one-clk pulse, y direction flipped this commit
corner  out  1  one-clk pulse, both flipped same commit
busy  out  1  high in CALC_X/CALC_Y/COMMIT
overrun  out  1  sticky, frame_start arrived while busy; cleared by reset or load

Behaviour:
- Reset (async): state IDLE; box_x/box_y/dir/pulses/overrun/busy = 0; frame-divider count = 0.
- States: IDLE, WAIT, CALC_X, CALC_Y, COMMIT.
- IDLE: load=1 copies load_x/load_y to box_x/box_y, clears dir_x/dir_y and overrun. Load values are clamped to SCREEN_W-1-BOX_SIZE and SCREEN_H-1-BOX_SIZE. Next state is WAIT if enable=1.
- WAIT: enable=0 -> IDLE. frame_start=1 and pause=0 -> divider count increments.
  - When the count equals frame_div, the count clears, speed is latched and the state goes to CALC_X.
  - pause=1 holds the count.
- CALC_X: computes next x into shadow registers using POS_W+1-bit arithmetic.
  - dir_x=0: if x+BOX_SIZE+speed >= SCREEN_W-1, then x = SCREEN_W-1-BOX_SIZE and the direction flips; else x += speed.
  - dir_x=1: if x < speed, then x = 0 and the direction flips; else x -= speed.
- CALC_Y: same rules with SCREEN_H and y.
- COMMIT: shadows copy to box_x/box_y/dir_x/dir_y; bounce_x/bounce_y/corner pulse for exactly one cycle; state returns to WAIT.
- Latency: the edge sampling a qualifying frame_start is edge N. Outputs update at edge N+3 and pulses are high during the cycle following that edge.
- speed=0: positions are unchanged, no flips, no pulses. Dir-0 compare still applies; at the maximum coordinate it re-clamps to the same value with a flip, which is allowed.
- frame_start while busy: dropped, overrun sets; the in-flight update completes unchanged.
- enable=0 or pause=1 mid-update: the update completes, then the FSM obeys the input in WAIT.
- load outside IDLE: ignored.
- Outputs change only in COMMIT, IDLE load or reset, so there is no mid-frame tearing.

Decomposition:
- Shared package vga_pkg holds SCREEN_W/SCREEN_H defaults, the POS_W constant and the state enum encoding, all reused by the sync generator and renderer.
- One natural sub-module: axis_step (combinational bounce/clamp for one axis, parameterised by limit). It is instantiated twice, or once and time-shared across CALC_X/CALC_Y. Time-sharing is preferred.

Test Plan:
- Reset, load (0,0), enable=1, speed=5, frame_div=0, one frame_start -> box=(5,5) exactly 3 edges later; no pulses, busy high for 3 cycles.
- Load x=435, dir right, speed=5, one frame -> box_x=439, dir_x=1, bounce_x one cycle; load y=275 -> box_y=279, dir_y=1, bounce_y and corner in the same cycle.
- Left edge: from x=439 leftward, after enough updates reach x=4, next frame -> box_x=0, dir_x=0, bounce_x pulse.
- frame_div=2: 6 frame_start strobes -> exactly 2 commits; pause=1 during 3 strobes -> no commits and divider count held.
- Second frame_start 1 cycle after the first -> overrun=1, a single commit of +5 only; load in IDLE clears overrun.
- Assert reset during CALC_Y -> immediate IDLE, box=(0,0), busy=0, no commit pulse afterward.
